serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
- Bit-serial multi-bit adder built around one instance of the team's 1-bit full adder cell FADDER.
- Accepts two WIDTH-bit operands and a carry-in with a start strobe.
- Presents operand bits LSB-first to FADDER, one bit per clock, and recirculates FADDER's carry through a flop.
- Assembles the sum in a shift register; reports sum, carry-out and signed overflow with a one-cycle done pulse.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request; sampled only in IDLE.
a  input  WIDTH  operand A; captured on the accepted start.
b  input  WIDTH  operand B; captured on the accepted start.
cin  input  1  carry-in; captured on the accepted start.
busy  output  1  high while bits are being processed.
done  output  1  one-cycle pulse when the result registers update.
sum  output  WIDTH  registered result (a+b+cin) mod 2^WIDTH.
cout  output  1  registered unsigned carry-out.
ovf  output  1  registered signed overflow: carry into MSB XOR cout.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - busy=0, done=0, sum=0, cout=0, ovf=0.
  - Internal shift registers, carry flop and bit counter cleared.
  - Takes effect immediately, including mid-operation. The aborted operation produces no done and does not update sum/cout/ovf.
- FSM states:
  - IDLE: on edge with start=1, load a_sh<=a, b_sh<=b, carry<=cin, cnt<=0; go to RUN. start=0 keeps IDLE.
  - RUN: busy=1. Each edge:
    - FADDER inputs: x=a_sh[0], y=b_sh[0], z=carry.
    - s_sh<={s,s_sh[WIDTH-1:1]}.
    - a_sh, b_sh shift right by 1.
    - carry<=c; cnt<=cnt+1.
    - On the edge where cnt==WIDTH-1:
      - sum<={s,s_sh[WIDTH-1:1]}, cout<=c, ovf<=c^carry.
      - done<=1, busy<=0, state<=DONE.
  - DONE: one cycle with done=1, busy=0; next edge: done<=0, state<=IDLE. start in DONE is ignored.
- Latency:
  - start sampled at edge k → busy high from edge k+1.
  - done high in the cycle after edge k+WIDTH. Exactly WIDTH clocks from acceptance to done.
  - Back-to-back throughput: one operation per WIDTH+2 cycles.
- start while busy or in DONE: ignored. No queuing; a/b/cin changes ignored after capture.
- sum/cout/ovf hold their value from the done cycle until the next completed operation. They never show partial results.
- cnt width: clog2(WIDTH). No wrap occurs, since RUN exits at WIDTH-1.
- Unreachable state encodings return to IDLE with busy=0, done=0.

Decomposition:
- Shared package serial_add_pkg:
  - State encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - Default WIDTH constant.
- Sub-module: exactly one FADDER instance (port order s,c,x,y,z). No other hierarchy.
- FSM, counter, shift registers and result registers live in serial_add_ctrl.

Test Plan:
1. WIDTH=8, a=8'h35, b=8'h4A, cin=0, start pulse → after 8 clocks done=1, sum=8'h7F, cout=0, ovf=0. busy high exactly 8 cycles.
2. a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1, ovf=0.
3. a=8'h7F, b=8'h01, cin=0 → sum=8'h80, cout=0, ovf=1. Then a=8'h80, b=8'h80 → sum=8'h00, cout=1, ovf=1.
4. a=8'hFF, b=8'hFF, cin=1 → sum=8'hFF, cout=1, ovf=0. Between completions sum holds the previous value (8'h00 from scenario 3).
5. Start accepted, then start held high and a/b changed during RUN and DONE → only one done pulse; result matches the originally captured operands. The next start in IDLE is accepted normally.
6. rst_n asserted after 3 RUN cycles → busy=0, done=0, sum/cout/ovf=0 immediately. No done follows. Release, run a=8'h12, b=8'h34, cin=1 → sum=8'h47, cout=0, ovf=0.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_add_pkg;

    // Default operand/sum width in bits (legal range 2..32).
    localparam int unsigned DEFAULT_WIDTH = 8;

    // Controller states; encoding 2'd3 is unreachable and recovers to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/FADDER.sv
// 1-bit full adder cell: s = x ^ y ^ z, c = majority(x, y, z).
module FADDER (
    output logic s,
    output logic c,
    input  logic x,
    input  logic y,
    input  logic z
);

    // Pure combinational sum and carry.
    always_comb begin
        s = x ^ y ^ z;
        c = (x & y) | (z & (x ^ y));
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: feeds operand bits LSB-first through one FADDER,
// recirculates the carry through a flop and assembles the sum in a shift register.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned    CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, b_sh_q;
    // Only the upper WIDTH-1 sum bits need storage: the final bit comes
    // straight from FADDER on the completing edge.
    logic [WIDTH-1:1] s_sh_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;

    logic             load;
    logic             step;
    logic             finish;
    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] sum_next;

    FADDER u_fadder (
        .s (fa_s),
        .c (fa_c),
        .x (a_sh_q[0]),
        .y (b_sh_q[0]),
        .z (carry_q)
    );

    // Newest FADDER sum bit enters at the MSB; after WIDTH steps the LSB lands at bit 0.
    assign sum_next = {fa_s, s_sh_q};

    // Next-state and status decode; unreachable encodings fall back to idle.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    finish  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand shifters, carry recirculation flop and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else if (load) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            s_sh_q  <= '0;
            carry_q <= cin;
            cnt_q   <= '0;
        end else if (step) begin
            a_sh_q  <= {1'b0, a_sh_q[WIDTH-1:1]};
            b_sh_q  <= {1'b0, b_sh_q[WIDTH-1:1]};
            s_sh_q  <= sum_next[WIDTH-1:1];
            carry_q <= fa_c;
            cnt_q   <= cnt_q + CNT_W'(1);
        end
    end

    // Result registers update only on the completing edge, so no partial sums leak out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else if (finish) begin
            sum  <= sum_next;
            cout <= fa_c;
            // carry_q here is the carry into the MSB.
            ovf  <= fa_c ^ carry_q;
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed cases plus random operands,
// compared against an arithmetic reference model.
module tb_serial_add_ctrl;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int errors = 0;
    int checks = 0;

    // Last completed result the DUT should be presenting.
    logic [W-1:0] held_sum;
    logic         held_cout;
    logic         held_ovf;

    serial_add_ctrl #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One operation; with hold_start the start line stays high and the operands
    // are scrambled during RUN and DONE, which the DUT must ignore.
    task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic ocin,
                          input bit hold_start);
        logic [W:0]   full;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        logic         exp_ovf;
        int           busy_cnt;
        bit           got_done;

        full     = {1'b0, oa} + {1'b0, ob} + {{W{1'b0}}, ocin};
        exp_sum  = full[W-1:0];
        exp_cout = full[W];
        exp_ovf  = (oa[W-1] == ob[W-1]) && (exp_sum[W-1] != oa[W-1]);

        @(negedge clk);
        a     = oa;
        b     = ob;
        cin   = ocin;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold_start) start = 1'b0;

        busy_cnt = 0;
        got_done = 1'b0;
        for (int i = 0; i < 4 * W; i++) begin
            @(negedge clk);
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (busy) begin
                busy_cnt++;
                check("hold_result", {cout, ovf, sum}, {held_cout, held_ovf, held_sum});
            end
            if (hold_start) begin
                a   = W'($urandom);
                b   = W'($urandom);
                cin = 1'($urandom);
            end
        end

        check("done_seen", 64'(got_done), 64'd1);
        check("busy_cycles", 64'(busy_cnt), 64'(W));
        check("busy_in_done", 64'(busy), 64'd0);
        check("sum", 64'(sum), 64'(exp_sum));
        check("cout", 64'(cout), 64'(exp_cout));
        check("ovf", 64'(ovf), 64'(exp_ovf));
        held_sum  = exp_sum;
        held_cout = exp_cout;
        held_ovf  = exp_ovf;

        if (hold_start) begin
            a = W'($urandom);
            b = W'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        check("done_one_cycle", 64'(done), 64'd0);
        check("idle_after_done", 64'(busy), 64'd0);
    endtask

    initial begin
        int stray_done;

        rst_n     = 1'b1;
        start     = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        held_sum  = '0;
        held_cout = 1'b0;
        held_ovf  = 1'b0;

        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_state", {59'd0, busy, done, cout, ovf, 1'b0}, 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        rst_n = 1'b1;

        // Directed cases.
        run_op(8'h35, 8'h4A, 1'b0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0);
        run_op(8'h7F, 8'h01, 1'b0, 1'b0);
        run_op(8'h80, 8'h80, 1'b0, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0);

        // start held high with operands changing after capture.
        run_op(8'h5A, 8'hC3, 1'b1, 1'b1);
        run_op(8'h01, 8'h02, 1'b0, 1'b0);

        // Asynchronous reset three cycles into RUN.
        @(negedge clk);
        a     = 8'hAA;
        b     = 8'h55;
        cin   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_result", {55'd0, cout, ovf, sum}, 64'd0);
        held_sum  = '0;
        held_cout = 1'b0;
        held_ovf  = 1'b0;
        @(negedge clk);
        rst_n      = 1'b1;
        stray_done = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            if (done || busy) stray_done++;
        end
        check("no_done_after_abort", 64'(stray_done), 64'd0);
        run_op(8'h12, 8'h34, 1'b1, 1'b0);

        // Random operands.
        for (int i = 0; i < 24; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), bit'($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
